// File: rtl/palette_lookup_arbiter.sv
// palette_lookup_arbiter
//   Shares one 16-entry x 12-bit RGB palette ROM between N_REQ pixel sources.
//   Round-robin arbitration, one lookup per cycle. The response register
//   holds the colour and the id of the requester that owns it.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req[N_REQ]            per-requester lookup request (held until gnt)
//   req_index[4*N_REQ]    palette index, requester i uses [4i+3:4i]
//   gnt[N_REQ]            one-hot grant, combinational, index consumed now
//   rsp_valid/rsp_ready   response handshake
//   rsp_id                owner of the response
//   red, green, blue      looked-up (optionally faded) colour
//   fade_start, fade_dir  begin a fade (1 = out, 0 = in)
//   fade_busy             fade in progress
//
// Build option
//   PALETTE_FADE_EN       enables the fade level that scales every response.
//                         Without it the fade inputs are ignored, fade_busy
//                         is 0 and colours are unscaled.
module palette_lookup_arbiter #(
   parameter int N_REQ    = 3,
   parameter int ID_W     = 2,
   parameter int FADE_DIV = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req,
   input  logic [4*N_REQ-1:0] req_index,
   output logic [N_REQ-1:0]   gnt,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [ID_W-1:0]    rsp_id,
   output logic [3:0]         red,
   output logic [3:0]         green,
   output logic [3:0]         blue,
   input  logic               fade_start,
   input  logic               fade_dir,
   output logic               fade_busy
);

   function automatic logic [11:0] palette(input logic [3:0] i);
      case (i)
         4'd0:    palette = 12'hFD7;
         4'd1:    palette = 12'h442;
         4'd2:    palette = 12'h6DF;
         4'd3:    palette = 12'h763;
         4'd4:    palette = 12'hF00;
         4'd5:    palette = 12'h221;
         4'd6:    palette = 12'h772;
         default: palette = 12'h763;
      endcase
   endfunction

   // c * (L+1) / 16; L = 15 is the identity
   function automatic logic [3:0] scale(input logic [3:0] c, input logic [3:0] l);
      logic [8:0] p;
      p = {5'd0, c} * ({5'd0, l} + 9'd1);
      p = p >> 4;
      return p[3:0];
   endfunction

   logic [3:0]      lvl;
   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] gidx;
   logic [ID_W-1:0] j;
   logic            found;
   logic            advance;
   logic [3:0]      idx_arr [N_REQ];
   logic [11:0]     rgb;

   for (genvar g = 0; g < N_REQ; g++) begin : g_idx
      assign idx_arr[g] = req_index[4*g +: 4];
   end

   assign advance = !rsp_valid || rsp_ready;

   // first asserted request at or after ptr, wrapping
   always_comb begin
      gnt   = '0;
      gidx  = '0;
      j     = '0;
      found = 1'b0;
      if (advance) begin
         for (int k = 0; k < N_REQ; k++) begin
            j = ID_W'((int'(ptr) + k) % N_REQ);
            if (!found && req[j]) begin
               found  = 1'b1;
               gnt[j] = 1'b1;
               gidx   = j;
            end
         end
      end
   end

   assign rgb = palette(idx_arr[gidx]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         red       <= '0;
         green     <= '0;
         blue      <= '0;
         ptr       <= '0;
      end else if (advance) begin
         rsp_valid <= found;
         if (found) begin
            rsp_id <= gidx;
            red    <= scale(rgb[11:8], lvl);
            green  <= scale(rgb[7:4],  lvl);
            blue   <= scale(rgb[3:0],  lvl);
            ptr    <= (gidx == ID_W'(N_REQ-1)) ? '0 : gidx + 1'b1;
         end
      end
   end

`ifdef PALETTE_FADE_EN
   localparam int PW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

   logic [PW-1:0] presc;
   logic          fdir;
   logic          busy;
   logic [3:0]    nxt;

   assign fade_busy = busy;

   // saturating step so a start at the reached endpoint leaves L alone
   always_comb begin
      if (fdir) nxt = (lvl == 4'd0)  ? 4'd0  : lvl - 4'd1;
      else      nxt = (lvl == 4'd15) ? 4'd15 : lvl + 4'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lvl   <= 4'd15;
         busy  <= 1'b0;
         fdir  <= 1'b0;
         presc <= '0;
      end else if (!busy) begin
         if (fade_start) begin
            busy  <= 1'b1;
            fdir  <= fade_dir;
            presc <= '0;
         end
      end else if (presc == PW'(FADE_DIV-1)) begin
         presc <= '0;
         lvl   <= nxt;
         if (nxt == (fdir ? 4'd0 : 4'd15)) busy <= 1'b0;
      end else begin
         presc <= presc + 1'b1;
      end
   end
`else
   logic unused_fade;
   assign unused_fade = fade_start ^ fade_dir ^ (FADE_DIV == 0);
   assign lvl         = 4'd15;
   assign fade_busy   = 1'b0;
`endif

endmodule

// File: tb/tb_palette_lookup_arbiter.sv
module tb_palette_lookup_arbiter;
   localparam int N = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  req = '0;
   logic [4*N-1:0] req_index = '0;
   logic [N-1:0]  gnt;
   logic          rsp_valid, rsp_ready = 1'b0;
   logic [1:0]    rsp_id;
   logic [3:0]    red, green, blue;
   logic          fade_start = 1'b0, fade_dir = 1'b0;
   logic          fade_busy;

   palette_lookup_arbiter #(.N_REQ(N), .ID_W(2), .FADE_DIV(4)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_index(req_index), .gnt(gnt),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .red(red), .green(green), .blue(blue),
      .fade_start(fade_start), .fade_dir(fade_dir), .fade_busy(fade_busy));

   always #5 clk = ~clk;

   typedef struct { int id; logic [11:0] rgb; } exp_t;
   exp_t q[$];

   int errors = 0, checks = 0;

   // reference state: what each source wants, and the fairness/fade view
   bit       pend [N];
   logic [3:0] pidx [N];
   int       waitc [N];
   int       mptr = 0;
   bit       mvalid = 0;
   int       mL = 15, fcnt = 0, fdirm = 0;
   bit       fbusy = 0;
   int       busy_cycles = 0;

   function automatic logic [11:0] pal(input logic [3:0] i);
      logic [11:0] t [16];
      t[0] = 12'hFD7; t[1] = 12'h442; t[2] = 12'h6DF; t[3] = 12'h763;
      t[4] = 12'hF00; t[5] = 12'h221; t[6] = 12'h772;
      for (int k = 7; k < 16; k++) t[k] = 12'h763;
      return t[i];
   endfunction

   function automatic logic [11:0] faded(input logic [11:0] c, input int l);
      int r, g, b;
      r = (int'(c[11:8]) * (l + 1)) / 16;
      g = (int'(c[7:4])  * (l + 1)) / 16;
      b = (int'(c[3:0])  * (l + 1)) / 16;
      return {r[3:0], g[3:0], b[3:0]};
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // mode: 0 no new requests, 1 random new requests, 2 everyone keeps asking
   task automatic step(input int mode, input int ready_pct);
      logic [N-1:0] eg;
      int gid;
      bit adv;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         if (mode == 1 && !pend[i] && $urandom_range(0, 1) == 1) begin
            pend[i] = 1;
            pidx[i] = 4'($urandom_range(0, 15));
         end
         if (mode == 2) pend[i] = 1;
         req[i] = pend[i];
         req_index[4*i +: 4] = pidx[i];
      end
      rsp_ready = ($urandom_range(0, 99) < ready_pct);
      #1;
      chk("rsp_valid", rsp_valid, mvalid);
`ifdef PALETTE_FADE_EN
      chk("fade_busy", fade_busy, fbusy);
`else
      chk("fade_busy", fade_busy, 0);
`endif
      if (fade_busy) busy_cycles++;
      adv = !mvalid || rsp_ready;
      eg = '0;
      gid = -1;
      if (adv)
         for (int k = 0; k < N; k++)
            if (gid < 0 && pend[(mptr + k) % N]) gid = (mptr + k) % N;
      if (gid >= 0) eg[gid] = 1'b1;
      chk("gnt", gnt, eg);
      if (gid >= 0) begin
         q.push_back('{gid, faded(pal(pidx[gid]), mL)});
         if (waitc[gid] >= N) begin
            errors++;
            $display("FAIL starve: req %0d waited %0d grants, limit %0d", gid, waitc[gid], N - 1);
         end
         for (int i = 0; i < N; i++) if (pend[i] && i != gid) waitc[i]++;
         waitc[gid] = 0;
         pend[gid] = 0;
         mptr = (gid + 1) % N;
      end
      if (adv) mvalid = (gid >= 0);
`ifdef PALETTE_FADE_EN
      // fade view for the coming edge: one level step per 4 busy cycles
      if (fbusy) begin
         fcnt++;
         if (fcnt == 4) begin
            fcnt = 0;
            mL = fdirm ? ((mL > 0) ? mL - 1 : 0) : ((mL < 15) ? mL + 1 : 15);
            if (mL == (fdirm ? 0 : 15)) fbusy = 0;
         end
      end else if (fade_start) begin
         fbusy = 1; fcnt = 0; fdirm = fade_dir;
      end
`endif
   endtask

   // monitor: a response shown with rsp_ready high is taken at the next edge
   initial forever begin
      exp_t e;
      @(negedge clk);
      #2;
      if (rst_n && rsp_valid && rsp_ready) begin
         if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rsp: id %0d rgb %0h with empty queue", rsp_id, {red, green, blue});
         end else begin
            e = q.pop_front();
            chk("rsp_id", rsp_id, e.id);
            chk("rsp_rgb", {red, green, blue}, e.rgb);
         end
      end
   end

   task automatic model_reset();
      q.delete();
      for (int i = 0; i < N; i++) begin pend[i] = 0; waitc[i] = 0; end
      mptr = 0; mvalid = 0; mL = 15; fbusy = 0; fcnt = 0;
   endtask

   initial begin
      model_reset();
      for (int i = 0; i < N; i++) pidx[i] = '0;
      #1;
      chk("reset_valid", rsp_valid, 0);
      chk("reset_rgb", {rsp_id, red, green, blue}, 0);
      chk("reset_busy", fade_busy, 0);
      @(negedge clk); rst_n = 1'b1;

      // single requester, index 4
      pend[1] = 1; pidx[1] = 4'd4;
      step(0, 100);
      step(0, 100);
      step(0, 100);

      // everyone asking with 0/2/5, full throughput
      pidx[0] = 4'd0; pidx[1] = 4'd2; pidx[2] = 4'd5;
      for (int c = 0; c < 9; c++) step(2, 100);

      // backpressure with a response pending
      for (int c = 0; c < 3; c++) step(2, 0);
      for (int c = 0; c < 4; c++) step(2, 100);

      // reset while a response is valid
      @(negedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", rsp_valid, 0);
      chk("midrst_out", {rsp_id, red, green, blue}, 0);
      model_reset();
      req = '0;
      @(negedge clk);
      @(negedge clk); rst_n = 1'b1;
      pidx[0] = 4'd15; pidx[1] = 4'd15; pidx[2] = 4'd15;
      for (int c = 0; c < 4; c++) step(2, 100);

      // random traffic and random backpressure
      for (int c = 0; c < 400; c++) step(1, 70);

`ifdef PALETTE_FADE_EN
      // fade out with requester 0 reading index 0 every cycle
      for (int c = 0; c < 10; c++) step(0, 100);
      busy_cycles = 0;
      for (int i = 0; i < N; i++) pend[i] = 0;
      pidx[0] = 4'd0;
      for (int c = 0; c < 75; c++) begin
         pend[0] = 1;
         fade_start = (c == 0 || c == 20);
         fade_dir   = (c == 0);
         step(0, 100);
      end
      fade_start = 1'b0;
      chk("fade_busy_cycles", busy_cycles, 60);
      chk("fade_end_level", mL, 0);
      pend[0] = 0;
`endif

      // drain
      for (int c = 0; c < 20; c++) step(0, 100);
      chk("queue_empty", q.size(), 0);
      chk("all_served", {pend[0], pend[1], pend[2]}, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
